// File: rtl/soc_irq_pkg.sv
// Shared definitions for the TV80 SoC RST-vector interrupt path.
// Used by the vector encoder (index -> RST opcode) and by the acknowledge
// decoder (RST opcode -> index), so both sides agree on the mapping.
//   RST_OPCODE_MASK : fixed bits of an RST n opcode (11 nnn 111)
//   REG_MASK/REG_PENDING : CPU-visible register addresses
//   ack_state_t     : acknowledge FSM states
package soc_irq_pkg;

  localparam logic [7:0] RST_OPCODE_MASK = 8'hC7;

  localparam logic REG_MASK    = 1'b0;
  localparam logic REG_PENDING = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DECODE,
    WAIT
  } ack_state_t;

  // Source 7 (highest priority) maps to RST 00h, source 0 to RST 38h.
  function automatic logic [2:0] vec_to_index(input logic [7:0] v);
    return 3'd7 - v[5:3];
  endfunction

  function automatic logic [7:0] index_to_vec(input logic [2:0] idx);
    return RST_OPCODE_MASK | {2'b00, 3'd7 - idx, 3'b000};
  endfunction

  function automatic logic is_rst_vec(input logic [7:0] v);
    return (v & RST_OPCODE_MASK) == RST_OPCODE_MASK;
  endfunction

endpackage

// File: rtl/irq_pending_bit.sv
// One pending-interrupt latch.
//   EDGE=1: set on a rising edge of src (src high, src_q low); clr drops it,
//           but a same-cycle set takes priority so no event is lost.
//   EDGE=0: pending simply follows the registered level of src; clr ignored.
// Ports: clk, reset (sync, active high), src (raw input), src_q (src delayed
// one cycle), clr (clear request), pending (latched state).
module irq_pending_bit #(
  parameter logic EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic src_q,
  input  logic clr,
  output logic pending
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (EDGE) begin
      if (src && !src_q) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end else begin
      pending <= src;
    end
  end

endmodule

// File: rtl/irq_ack_ctrl.sv
// Acknowledge-side companion to the RST-vector interrupt controller.
// Latches peripheral events into pending bits, gates them with a software
// mask onto irq[7:0], and watches the Z80 interrupt-acknowledge cycle to
// clear the pending bit selected by the RST vector the CPU fetched.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   m1_n, iorq_n, cpu_di: CPU M1/IORQ strobes and data bus (vector)
//   cs_n, wr_n, rd_n    : register select and I/O strobes (active low)
//   addr, data_in       : register address (0 MASK, 1 PENDING), write data
//   data_out            : read data, 0 when not selected
//   irq_src             : peripheral interrupt inputs
//   irq                 : pending & mask, registered
//   ack_valid/ack_index : decoded-acknowledge pulse and held source index
//   ack_err             : sticky non-RST-vector flag
module irq_ack_ctrl
  import soc_irq_pkg::*;
#(
  parameter logic [7:0] EDGE_MASK  = 8'hFF,
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic [7:0] cpu_di,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [7:0] irq_src,
  output logic [7:0] irq,
  output logic       ack_valid,
  output logic [2:0] ack_index,
  output logic       ack_err
);

  ack_state_t state_q, state_d;
  logic [7:0] src_q;
  logic [7:0] mask_q;
  logic [7:0] pending;
  logic [7:0] vec_q;
  logic [7:0] clr;
  logic       wr_q;
  logic       wr_fire;
  logic       dec_ok;
  logic       dec_bad;

  // One register write per strobe: act only on the falling edge of wr_n.
  assign wr_fire = !cs_n && !wr_n && wr_q;

  always_comb begin
    clr = '0;
    if (dec_ok) begin
      clr = 8'h01 << vec_to_index(vec_q);
    end
    if (wr_fire && addr == REG_PENDING) begin
      clr = clr | data_in;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_pend
    irq_pending_bit #(
      .EDGE(EDGE_MASK[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .src    (irq_src[i]),
      .src_q  (src_q[i]),
      .clr    (clr[i]),
      .pending(pending[i])
    );
  end

  always_comb begin
    state_d = state_q;
    dec_ok  = 1'b0;
    dec_bad = 1'b0;
    case (state_q)
      IDLE:   if (!m1_n && !iorq_n) state_d = ACK;
      ACK:    if (iorq_n) state_d = DECODE;
      DECODE: begin
        if (is_rst_vec(vec_q)) dec_ok = 1'b1;
        else                   dec_bad = 1'b1;
        state_d = WAIT;
      end
      WAIT:   if (m1_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      mask_q    <= RESET_MASK;
      irq       <= '0;
      wr_q      <= 1'b1;
      vec_q     <= '0;
      ack_valid <= 1'b0;
      ack_index <= '0;
      ack_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      irq       <= pending & mask_q;
      wr_q      <= wr_n;
      ack_valid <= dec_ok;
      if (state_q == ACK && !iorq_n) begin
        vec_q <= cpu_di;
      end
      if (wr_fire && addr == REG_MASK) begin
        mask_q <= data_in;
      end
      if (dec_ok) begin
        ack_index <= vec_to_index(vec_q);
      end
      if (dec_bad) begin
        ack_err <= 1'b1;
      end else if (wr_fire && addr == REG_PENDING && data_in == 8'h00) begin
        ack_err <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (!cs_n && !rd_n) begin
      data_out = (addr == REG_MASK) ? mask_q : pending;
    end
  end

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Directed bench for irq_ack_ctrl. Two instances share all stimulus: u_dut
// with default parameters (all edge sources) and u_lvl with bit 0 as a level
// source. Inputs change and outputs are sampled 1 time unit after posedge.
module tb_irq_ack_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_n, iorq_n;
  logic [7:0] cpu_di;
  logic       cs_n, wr_n, rd_n, addr;
  logic [7:0] data_in;
  logic [7:0] irq_src;

  logic [7:0] data_out, irq;
  logic       ack_valid, ack_err;
  logic [2:0] ack_index;

  logic [7:0] data_out2, irq2;
  logic       ack_valid2, ack_err2;
  logic [2:0] ack_index2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_ack_ctrl u_dut (
    .clk(clk), .reset(reset), .m1_n(m1_n), .iorq_n(iorq_n), .cpu_di(cpu_di),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq_src(irq_src), .irq(irq), .ack_valid(ack_valid),
    .ack_index(ack_index), .ack_err(ack_err)
  );

  irq_ack_ctrl #(.EDGE_MASK(8'hFE)) u_lvl (
    .clk(clk), .reset(reset), .m1_n(m1_n), .iorq_n(iorq_n), .cpu_di(cpu_di),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .addr(addr), .data_in(data_in),
    .data_out(data_out2), .irq_src(irq_src), .irq(irq2), .ack_valid(ack_valid2),
    .ack_index(ack_index2), .ack_err(ack_err2)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic a, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; data_in = d;
    tick();
    wr_n = 1'b1; cs_n = 1'b1;
    tick();
  endtask

  task automatic read_reg(input logic a, output logic [7:0] d1, output logic [7:0] d2);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    #1;
    d1 = data_out;
    d2 = data_out2;
    cs_n = 1'b1; rd_n = 1'b1;
    #1;
  endtask

  task automatic pulse_src(input logic [7:0] bits, input logic [7:0] hold);
    irq_src = bits | hold;
    tick();
    irq_src = hold;
    tick();
  endtask

  // Ends just after the edge that moves the FSM from ACK to DECODE.
  task automatic ack_cycle(input logic [7:0] v);
    m1_n = 1'b0;
    tick();
    iorq_n = 1'b0; cpu_di = v;
    tick();
    tick();
    iorq_n = 1'b1; m1_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] r1, r2;
    reset = 1'b1; m1_n = 1'b1; iorq_n = 1'b1; cpu_di = '0;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; addr = 1'b0; data_in = '0; irq_src = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check_eq("rst_irq", irq, 8'h00);
    check_eq("rst_ack_valid", 8'(ack_valid), 8'h00);
    check_eq("rst_ack_index", 8'(ack_index), 8'h00);
    check_eq("rst_ack_err", 8'(ack_err), 8'h00);
    check_eq("rst_data_out_idle", data_out, 8'h00);
    read_reg(1'b0, r1, r2);
    check_eq("rst_mask", r1, 8'h00);
    read_reg(1'b1, r1, r2);
    check_eq("rst_pending", r1, 8'h00);

    // edge latch and acknowledge of source 7
    write_reg(1'b0, 8'hFF);
    pulse_src(8'h80, 8'h00);
    check_eq("edge_irq", irq, 8'h80);
    ack_cycle(8'hC7);
    check_eq("ack7_no_early_pulse", 8'(ack_valid), 8'h00);
    tick();
    check_eq("ack7_valid", 8'(ack_valid), 8'h01);
    check_eq("ack7_index", 8'(ack_index), 8'h07);
    check_eq("ack7_irq_still", irq, 8'h80);
    read_reg(1'b1, r1, r2);
    check_eq("ack7_pending_clr", r1, 8'h00);
    tick();
    check_eq("ack7_valid_drop", 8'(ack_valid), 8'h00);
    check_eq("ack7_irq_drop", irq, 8'h00);
    check_eq("ack7_index_held", 8'(ack_index), 8'h07);

    // masking
    write_reg(1'b0, 8'h00);
    pulse_src(8'h04, 8'h00);
    check_eq("mask_irq_gated", irq, 8'h00);
    read_reg(1'b1, r1, r2);
    check_eq("mask_pending", r1, 8'h04);
    write_reg(1'b0, 8'h04);
    check_eq("mask_irq_open", irq, 8'h04);
    write_reg(1'b1, 8'h04);
    read_reg(1'b1, r1, r2);
    check_eq("w1c_bit2", r1, 8'h00);

    // set beats ack clear on the same edge
    write_reg(1'b0, 8'hFF);
    pulse_src(8'h01, 8'h00);
    ack_cycle(8'hFF);
    irq_src = 8'h01;
    tick();
    check_eq("coll_valid", 8'(ack_valid), 8'h01);
    check_eq("coll_index", 8'(ack_index), 8'h00);
    read_reg(1'b1, r1, r2);
    check_eq("coll_pending", r1, 8'h01);
    irq_src = 8'h00;
    tick();
    check_eq("coll_irq", irq, 8'h01);
    write_reg(1'b1, 8'h01);

    // non-RST vector
    pulse_src(8'h20, 8'h00);
    ack_cycle(8'h3E);
    tick();
    check_eq("bad_no_valid", 8'(ack_valid), 8'h00);
    check_eq("bad_err", 8'(ack_err), 8'h01);
    tick();
    read_reg(1'b1, r1, r2);
    check_eq("bad_pending_kept", r1, 8'h20);
    check_eq("bad_err_sticky", 8'(ack_err), 8'h01);
    write_reg(1'b1, 8'h00);
    check_eq("bad_err_cleared", 8'(ack_err), 8'h00);
    write_reg(1'b1, 8'h20);

    // W1C against a level source (u_lvl bit 0)
    pulse_src(8'h08, 8'h01);
    read_reg(1'b1, r1, r2);
    check_eq("lvl_pending_set", r2, 8'h09);
    write_reg(1'b1, 8'h09);
    read_reg(1'b1, r1, r2);
    check_eq("lvl_w1c", r2, 8'h01);
    check_eq("lvl_irq", irq2, 8'h01);
    irq_src = 8'h00;
    tick();
    read_reg(1'b1, r1, r2);
    check_eq("lvl_follow_drop", r2, 8'h00);
    write_reg(1'b1, 8'hFF);

    // reset in the middle of an acknowledge
    pulse_src(8'h40, 8'h00);
    tick();
    check_eq("mid_irq_before", irq, 8'h40);
    m1_n = 1'b0; iorq_n = 1'b0; cpu_di = 8'hCF;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("mid_irq", irq, 8'h00);
    check_eq("mid_no_valid", 8'(ack_valid), 8'h00);
    iorq_n = 1'b1; m1_n = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    check_eq("mid_still_no_valid", 8'(ack_valid), 8'h00);
    read_reg(1'b1, r1, r2);
    check_eq("mid_pending_clr", r1, 8'h00);

    // opcode fetch alone keeps the FSM idle
    m1_n = 1'b0;
    tick(); tick(); tick();
    m1_n = 1'b1;
    tick(); tick();
    check_eq("fetch_no_valid", 8'(ack_valid), 8'h00);

    // normal acknowledge after reset
    write_reg(1'b0, 8'hFF);
    pulse_src(8'h40, 8'h00);
    ack_cycle(8'hCF);
    tick();
    check_eq("post_valid", 8'(ack_valid), 8'h01);
    check_eq("post_index", 8'(ack_index), 8'h06);
    tick();
    check_eq("post_irq", irq, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
